// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: request/result and ALU-sharing signals of the sequential multiplier
// ALU_MUL_SEQ_SIGNED_EN adds the op_signed request bit.
interface alu_mul_seq_if #(parameter int WIDTH = 32);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
`ifdef ALU_MUL_SEQ_SIGNED_EN
   logic             op_signed;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product_hi;
   logic [WIDTH-1:0] product_lo;
   logic [WIDTH-1:0] alu_src_a;
   logic [WIDTH-1:0] alu_src_b;
   logic [3:0]       alu_ctr;
   logic [WIDTH-1:0] alu_res;
   modport master (
      output start, op_a, op_b, alu_res,
`ifdef ALU_MUL_SEQ_SIGNED_EN
      output op_signed,
`endif
      input busy, done, product_hi, product_lo, alu_src_a, alu_src_b, alu_ctr
   );
   modport slave (
      input start, op_a, op_b, alu_res,
`ifdef ALU_MUL_SEQ_SIGNED_EN
      input op_signed,
`endif
      output busy, done, product_hi, product_lo, alu_src_a, alu_src_b, alu_ctr
   );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier that borrows the shared ALU adder once per multiplier bit
// ALU_MUL_SEQ_SIGNED_EN enables signed operands (abs on entry, negate on exit).
module alu_mul_seq #(
   parameter int         WIDTH    = 32,
   parameter logic [3:0] ADD_CTR  = 4'b0010,
   parameter logic [3:0] SUB_CTR  = 4'b0110,
   parameter logic [3:0] OR_CTR   = 4'b0001,
   parameter logic [3:0] IDLE_CTR = 4'b1111
) (
   input logic         clk,
   input logic         reset,
   alu_mul_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
`ifdef ALU_MUL_SEQ_SIGNED_EN
   typedef enum logic [2:0] {IDLE, CALC, DONE, PREP_A, PREP_B, FIX} state_t;
`else
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif
   state_t           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] product_hi_q, product_hi_d, product_lo_q, product_lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic [2*WIDTH-1:0] step;
`ifdef ALU_MUL_SEQ_SIGNED_EN
   logic             sgn_q, sgn_d, neg_q, neg_d;
   logic [2*WIDTH-1:0] fixed;
   assign fixed = neg_q ? ~{acc_hi_q, acc_lo_q} + (2*WIDTH)'(1) : {acc_hi_q, acc_lo_q};
`endif
   // An unsigned add overflowed exactly when the result wrapped below an operand.
   assign sum   = acc_lo_q[0] ? bus.alu_res : acc_hi_q;
   assign carry = acc_lo_q[0] & (bus.alu_res < acc_hi_q);
   assign step  = {carry, sum, acc_lo_q[WIDTH-1:1]};
   assign bus.busy       = state_q != IDLE;
   assign bus.done       = state_q == DONE;
   assign bus.product_hi = product_hi_q;
   assign bus.product_lo = product_lo_q;
   always_comb begin
      state_d      = state_q;
      mcand_d      = mcand_q;
      acc_hi_d     = acc_hi_q;
      acc_lo_d     = acc_lo_q;
      cnt_d        = cnt_q;
      product_hi_d = product_hi_q;
      product_lo_d = product_lo_q;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      sgn_d        = sgn_q;
      neg_d        = neg_q;
`endif
      bus.alu_src_a = '0;
      bus.alu_src_b = '0;
      bus.alu_ctr   = IDLE_CTR;
      case (state_q)
         IDLE: if (bus.start) begin
            mcand_d  = bus.op_a;
            acc_hi_d = '0;
            acc_lo_d = bus.op_b;
            cnt_d    = '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
            sgn_d    = bus.op_signed;
            state_d  = PREP_A;
`else
            state_d  = CALC;
`endif
         end
`ifdef ALU_MUL_SEQ_SIGNED_EN
         PREP_A: begin
            bus.alu_src_b = mcand_q;
            bus.alu_ctr   = (sgn_q & mcand_q[WIDTH-1]) ? SUB_CTR : OR_CTR;
            mcand_d       = bus.alu_res;
            neg_d         = sgn_q & mcand_q[WIDTH-1];
            state_d       = PREP_B;
         end
         PREP_B: begin
            bus.alu_src_b = acc_lo_q;
            bus.alu_ctr   = (sgn_q & acc_lo_q[WIDTH-1]) ? SUB_CTR : OR_CTR;
            acc_lo_d      = bus.alu_res;
            neg_d         = neg_q ^ (sgn_q & acc_lo_q[WIDTH-1]);
            state_d       = CALC;
         end
         FIX: begin
            {acc_hi_d, acc_lo_d}         = fixed;
            {product_hi_d, product_lo_d} = fixed;
            state_d                      = DONE;
         end
`endif
         CALC: begin
            bus.alu_src_a        = acc_hi_q;
            bus.alu_src_b        = mcand_q;
            bus.alu_ctr          = ADD_CTR;
            {acc_hi_d, acc_lo_d} = step;
            cnt_d                = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef ALU_MUL_SEQ_SIGNED_EN
               state_d = FIX;
`else
               {product_hi_d, product_lo_d} = step;
               state_d = DONE;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         mcand_q      <= '0;
         acc_hi_q     <= '0;
         acc_lo_q     <= '0;
         cnt_q        <= '0;
         product_hi_q <= '0;
         product_lo_q <= '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
         sgn_q        <= 1'b0;
         neg_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         mcand_q      <= mcand_d;
         acc_hi_q     <= acc_hi_d;
         acc_lo_q     <= acc_lo_d;
         cnt_q        <= cnt_d;
         product_hi_q <= product_hi_d;
         product_lo_q <= product_lo_d;
`ifdef ALU_MUL_SEQ_SIGNED_EN
         sgn_q        <= sgn_d;
         neg_q        <= neg_d;
`endif
      end
   end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed checks of the sequential multiplier against a behavioural ALU
// ALU_MUL_SEQ_SIGNED_EN also runs the signed-operand scenarios.
module tb_alu_mul_seq;
   localparam int W = 32;
`ifdef ALU_MUL_SEQ_SIGNED_EN
   localparam int LAT = W + 3;
   localparam int PRE = 2;
`else
   localparam int LAT = W;
   localparam int PRE = 0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec = 0;
   int   errs = 0;
   alu_mul_seq_if #(.WIDTH(W)) bus();
   alu_mul_seq #(.WIDTH(W)) dut (.clk(clk), .reset(rst), .bus(bus));
   always #5 clk = ~clk;
   always_comb
      bus.alu_res = bus.alu_ctr == 4'b0010 ? bus.alu_src_a + bus.alu_src_b :
                    bus.alu_ctr == 4'b0110 ? bus.alu_src_a - bus.alu_src_b :
                    bus.alu_ctr == 4'b0001 ? bus.alu_src_a | bus.alu_src_b : '0;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      bus.op_a  = a;
      bus.op_b  = b;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      bus.op_signed = s;
`else
      if (s) $display("note: signed request ignored in unsigned build");
`endif
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
   endtask
   task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic [W-1:0] eh, input logic [W-1:0] el);
      bit early = 0, idle = 0;
      launch(a, b, s);
      for (int i = 1; i <= LAT; i++) begin
         tick;
         if (i < LAT && bus.done) early = 1;
         if (!bus.busy) idle = 1;
      end
      vec++; if (early || idle) begin errs++; $display("FAIL %s timing: early_done=%0b busy_dropped=%0b, required 0/0", name, early, idle); end
      vec++; if (bus.done !== 1'b1) begin errs++; $display("FAIL %s done: got %b, required 1", name, bus.done); end
      vec++; if ({bus.product_hi, bus.product_lo} !== {eh, el}) begin errs++; $display("FAIL %s product: got %h_%h, required %h_%h", name, bus.product_hi, bus.product_lo, eh, el); end
      tick;
      vec++; if ({bus.busy, bus.done, bus.alu_ctr} !== {2'b00, 4'b1111}) begin errs++; $display("FAIL %s idle: busy=%b done=%b ctr=%h, required 0 0 f", name, bus.busy, bus.done, bus.alu_ctr); end
   endtask
   task automatic test_reset;
      bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      bus.op_signed = 1'b0;
`endif
      rst = 1'b1;
      tick; tick;
      vec++; if ({bus.busy, bus.done, bus.product_hi, bus.product_lo} !== '0) begin errs++; $display("FAIL reset outputs: busy=%b done=%b prod=%h_%h, required all 0", bus.busy, bus.done, bus.product_hi, bus.product_lo); end
      vec++; if ({bus.alu_ctr, bus.alu_src_a, bus.alu_src_b} !== {4'b1111, 64'd0}) begin errs++; $display("FAIL reset alu: ctr=%h a=%h b=%h, required f 0 0", bus.alu_ctr, bus.alu_src_a, bus.alu_src_b); end
      rst = 1'b0;
      tick;
   endtask
   task automatic test_calc_ports;
      logic [2*W-1:0] acc;
      logic [W:0] s;
      acc = {32'd0, 32'd5};
      launch(32'd3, 32'd5, 1'b0);
      repeat (PRE) tick;
      for (int k = 0; k < W; k++) begin
         vec++;
         if ({bus.busy, bus.alu_ctr, bus.alu_src_a, bus.alu_src_b} !== {1'b1, 4'b0010, acc[2*W-1:W], 32'd3}) begin
            errs++; $display("FAIL calc_port cycle %0d: busy=%b ctr=%h a=%h b=%h, required 1 2 %h 00000003", k, bus.busy, bus.alu_ctr, bus.alu_src_a, bus.alu_src_b, acc[2*W-1:W]);
         end
         s = {1'b0, acc[2*W-1:W]} + {1'b0, acc[0] ? 32'd3 : 32'd0};
         acc = {s, acc[W-1:1]};
         tick;
      end
`ifdef ALU_MUL_SEQ_SIGNED_EN
      tick;
`endif
      vec++; if ({bus.done, bus.product_hi, bus.product_lo} !== {1'b1, 32'h0, 32'hF}) begin errs++; $display("FAIL calc_3x5: done=%b prod=%h_%h, required 1 00000000_0000000f", bus.done, bus.product_hi, bus.product_lo); end
      tick;
      vec++; if (bus.alu_ctr !== 4'b1111) begin errs++; $display("FAIL calc_idle_ctr: got %h, required f", bus.alu_ctr); end
   endtask
   task automatic test_all_ones;
      run_check("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
   endtask
   task automatic test_ignore_start;
      int dones = 0;
      logic [2*W-1:0] got = '0;
      launch(32'h1234, 32'h10, 1'b0);
      for (int i = 1; i <= LAT + 10; i++) begin
         bus.start = (i == 10) || (i == LAT + 1);
         if (i == 10) begin bus.op_a = 32'h9; bus.op_b = 32'h9; end
         tick;
         bus.start = 1'b0;
         if (bus.done) begin dones++; got = {bus.product_hi, bus.product_lo}; end
         if (i == LAT + 1) begin
            vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL start_in_done: busy=%b, required 0", bus.busy); end
         end
      end
      vec++; if (dones !== 1) begin errs++; $display("FAIL ignore_done_count: got %0d, required 1", dones); end
      vec++; if (got !== 64'h12340) begin errs++; $display("FAIL ignore_product: got %h, required %h", got, 64'h12340); end
   endtask
   task automatic test_reset_abort;
      int dones = 0;
      launch(32'h7, 32'h9, 1'b0);
      repeat (14) tick;
      rst = 1'b1;
      #1;
      vec++; if ({bus.busy, bus.done, bus.product_hi, bus.product_lo} !== '0) begin errs++; $display("FAIL abort_outputs: busy=%b done=%b prod=%h_%h, required all 0", bus.busy, bus.done, bus.product_hi, bus.product_lo); end
      vec++; if (bus.alu_ctr !== 4'b1111) begin errs++; $display("FAIL abort_ctr: got %h, required f", bus.alu_ctr); end
      tick;
      rst = 1'b0;
      for (int i = 0; i < LAT + 8; i++) begin
         tick;
         if (bus.done || bus.busy) dones++;
      end
      vec++; if (dones !== 0) begin errs++; $display("FAIL abort_no_done: activity cycles %0d, required 0", dones); end
      run_check("after_abort_7x6", 32'h7, 32'h6, 1'b0, 32'h0, 32'h2A);
   endtask
   task automatic test_back_to_back;
      run_check("b2b_first", 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h1, 32'h0);
      repeat (3) tick;
      vec++; if ({bus.product_hi, bus.product_lo} !== {32'h1, 32'h0}) begin errs++; $display("FAIL hold_product: got %h_%h, required 00000001_00000000", bus.product_hi, bus.product_lo); end
      launch(32'hDEAD_BEEF, 32'h2, 1'b0);
      vec++; if ({bus.busy, bus.product_hi, bus.product_lo} !== {1'b1, 32'h1, 32'h0}) begin errs++; $display("FAIL start_keeps_product: busy=%b prod=%h_%h, required 1 00000001_00000000", bus.busy, bus.product_hi, bus.product_lo); end
      repeat (LAT) tick;
      vec++; if ({bus.done, bus.product_hi, bus.product_lo} !== {1'b1, 32'h1, 32'hBD5B_7DDE}) begin errs++; $display("FAIL b2b_second: done=%b prod=%h_%h, required 1 00000001_bd5b7dde", bus.done, bus.product_hi, bus.product_lo); end
      tick;
      run_check("b2b_immediate", 32'h0000_FFFF, 32'h0001_0001, 1'b0, 32'h0, 32'hFFFF_FFFF);
   endtask
`ifdef ALU_MUL_SEQ_SIGNED_EN
   task automatic test_signed;
      run_check("signed_m3x5", 32'hFFFF_FFFD, 32'h5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_check("unsigned_m3x5", 32'hFFFF_FFFD, 32'h5, 1'b0, 32'h4, 32'hFFFF_FFF1);
      run_check("signed_m3xm5", 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 32'h0, 32'hF);
   endtask
`endif
   initial begin
      test_reset;
      test_calc_ports;
      test_all_ones;
      test_ignore_start;
      test_reset_abort;
      test_back_to_back;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      test_signed;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
